vram_arbiter: RTL and testbench

Shares the single-port 8 KB video RAM between Chroni's text/font fetcher and the CPU. Each requester uses Chroni's level request / single-pulse acknowledge handshake. The arbiter applies a fixed-priority-plus-anti-starvation policy and sequences every RAM access, including read latency. It sits between chroni (addr_out/rd_req/rd_ack/data_in) and the RAM macro, in the sys_clk domain.

---
 rtl/vram_arb_pkg.sv | 14 +
 rtl/vram_arb_select.sv | 59 +++++
 rtl/vram_arbiter.sv | 119 +++++++++++
 tb/tb_vram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: FSM state encoding and grant owner encoding.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam logic GRANT_VIDEO = 1'b0;
    localparam logic GRANT_CPU   = 1'b1;

endpackage

// File: rtl/vram_arb_select.sv
// Combinational winner pick (anti-starvation, urgent video, round-robin tie) valid only while arb_en.
// Owns the last-grant pointer and the saturating CPU wait counter; requesters wait on level req.
module vram_arb_select
    import vram_arb_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 16
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic arb_en,
    input  logic video_req,
    input  logic video_urgent,
    input  logic cpu_req,
    input  logic cpu_served,
    output logic grant_valid,
    output logic winner
);

    localparam int                WAIT_W     = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(CPU_MAX_WAIT);

    logic [WAIT_W-1:0] cpu_wait;
    logic              last_grant;
    logic              cpu_starved;

    assign cpu_starved = cpu_req && (cpu_wait >= WAIT_LIMIT);
    assign grant_valid = arb_en && (video_req || cpu_req);

    always_comb begin
        winner = GRANT_VIDEO;
        if (cpu_starved) begin
            winner = GRANT_CPU;
        end else if (video_req && video_urgent) begin
            winner = GRANT_VIDEO;
        end else if (video_req && cpu_req) begin
            winner = ~last_grant;
        end else if (cpu_req) begin
            winner = GRANT_CPU;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            last_grant <= GRANT_CPU;
            cpu_wait   <= '0;
        end else begin
            if (grant_valid) begin
                last_grant <= winner;
            end
            // The counter only ages while the CPU is queued, not while its own access runs.
            if (grant_valid && (winner == GRANT_CPU)) begin
                cpu_wait <= '0;
            end else if (cpu_req && !cpu_served && (cpu_wait != '1)) begin
                cpu_wait <= cpu_wait + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between video fetch and CPU; read ack at t+2+MEM_LATENCY, write ack at t+2.
// Requesters hold a level req until a one-cycle ack; the FSM returns to IDLE between every access.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 8,
    parameter int MEM_LATENCY  = 1,
    parameter int CPU_MAX_WAIT = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              video_req,
    input  logic [ADDR_W-1:0] video_addr,
    input  logic              video_urgent,
    output logic              video_ack,
    output logic [DATA_W-1:0] video_rd_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              grant_cpu,
    output logic              busy
);

    localparam int               CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LATENCY - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             cur_we;
    logic             grant_valid;
    logic             winner;
    logic             cpu_served;
    logic             wait_done;

    assign cpu_served = (state != IDLE) && grant_cpu;
    assign wait_done  = (state == WAIT) && (wait_cnt == LAST_WAIT);

    vram_arb_select #(
        .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) u_sel (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .arb_en      (state == IDLE),
        .video_req   (video_req),
        .video_urgent(video_urgent),
        .cpu_req     (cpu_req),
        .cpu_served  (cpu_served),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    always_comb begin
        state_nxt = state;
        video_ack = 1'b0;
        cpu_ack   = 1'b0;
        mem_we    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_we    = cur_we;
                state_nxt = cur_we ? ACK : WAIT;
            end
            WAIT: begin
                if (wait_done) state_nxt = ACK;
            end
            ACK: begin
                video_ack = !grant_cpu;
                cpu_ack   = grant_cpu;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            grant_cpu     <= 1'b0;
            cur_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            video_rd_data <= '0;
            cpu_rd_data   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
            // Request fields are frozen at grant so the RAM side is immune to later input changes.
            if (grant_valid) begin
                grant_cpu <= (winner == GRANT_CPU);
                if (winner == GRANT_CPU) begin
                    mem_addr    <= cpu_addr;
                    mem_wr_data <= cpu_wr_data;
                    cur_we      <= cpu_we;
                end else begin
                    mem_addr <= video_addr;
                    cur_we   <= 1'b0;
                end
            end
            if (wait_done) begin
                if (grant_cpu) cpu_rd_data   <= mem_rd_data;
                else           video_rd_data <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench: directed and random traffic on a MEM_LATENCY=1 arbiter, plus a MEM_LATENCY=3 read check.
module tb_vram_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int MAXW = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cexp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asserts = 0;
    int n_fail    = 0;

    function automatic void chk(input bit ok, input string nm, input int act, input int req);
        n_asserts++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Memory contents seen by the RAM models and the reference model.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 13'h401) return 8'h41;
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [DW-1:0] f3(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    // DUT with MEM_LATENCY = 1
    logic          video_req, video_urgent, video_ack;
    logic [AW-1:0] video_addr;
    logic [DW-1:0] video_rd_data;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wr_data, cpu_rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic          grant_cpu, busy;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .CPU_MAX_WAIT(MAXW)) dut1 (
        .sys_clk(clk), .reset(reset),
        .video_req(video_req), .video_addr(video_addr), .video_urgent(video_urgent),
        .video_ack(video_ack), .video_rd_data(video_rd_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_ack(cpu_ack), .cpu_rd_data(cpu_rd_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .grant_cpu(grant_cpu), .busy(busy)
    );

    bit [DW-1:0] ram1    [8192];
    bit          ram1_wr [8192];
    always @(posedge clk) begin
        if (mem_we) begin
            ram1[mem_addr]    <= mem_wr_data;
            ram1_wr[mem_addr] <= 1'b1;
        end
        mem_rd_data <= ram1_wr[mem_addr] ? ram1[mem_addr] : init_val(mem_addr);
    end

    // DUT with MEM_LATENCY = 3, video reads only
    logic          v3_req, v3_ack, c3_ack, m3_we, g3, b3;
    logic [AW-1:0] v3_addr, m3_addr;
    logic [DW-1:0] v3_rd_data, c3_rd_data, m3_wr_data, m3_rd_data;
    logic [DW-1:0] p3 [3];

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .CPU_MAX_WAIT(MAXW)) dut3 (
        .sys_clk(clk), .reset(reset),
        .video_req(v3_req), .video_addr(v3_addr), .video_urgent(1'b0),
        .video_ack(v3_ack), .video_rd_data(v3_rd_data),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr('0), .cpu_wr_data('0),
        .cpu_ack(c3_ack), .cpu_rd_data(c3_rd_data),
        .mem_addr(m3_addr), .mem_we(m3_we), .mem_wr_data(m3_wr_data), .mem_rd_data(m3_rd_data),
        .grant_cpu(g3), .busy(b3)
    );

    always @(posedge clk) begin
        p3[0] <= f3(m3_addr);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m3_rd_data = p3[2];

    // Reference model and scoreboard
    bit [DW-1:0]   ref_mem [8192];
    logic [DW-1:0] exp_v [$];
    cexp_t         exp_c [$];
    bit            grant_order [$];
    logic [DW-1:0] mon_v;
    cexp_t         mon_c;

    always @(negedge clk) begin
        if (video_ack && cpu_ack) chk(1'b0, "ack_overlap", 1, 0);
        if (video_ack) begin
            grant_order.push_back(1'b0);
            if (exp_v.size() == 0) begin
                chk(1'b0, "video_spurious_ack", 1, 0);
            end else begin
                mon_v = exp_v.pop_front();
                chk(video_rd_data == mon_v, "video_rd_data", video_rd_data, mon_v);
            end
        end
        if (cpu_ack) begin
            grant_order.push_back(1'b1);
            if (exp_c.size() == 0) begin
                chk(1'b0, "cpu_spurious_ack", 1, 0);
            end else begin
                mon_c = exp_c.pop_front();
                if (mon_c.we) chk(ram1[mon_c.addr] == mon_c.data, "cpu_write_landed", ram1[mon_c.addr], mon_c.data);
                else          chk(cpu_rd_data == mon_c.data, "cpu_rd_data", cpu_rd_data, mon_c.data);
            end
        end
        if (mem_we) begin
            if (exp_c.size() > 0 && exp_c[0].we)
                chk(mem_addr == exp_c[0].addr && mem_wr_data == exp_c[0].data, "mem_write_bus",
                    {mem_addr, mem_wr_data}, {exp_c[0].addr, exp_c[0].data});
            else
                chk(1'b0, "mem_we_unexpected", {mem_addr, mem_wr_data}, 0);
        end
    end

    task automatic video_read(input logic [AW-1:0] a, output int lat);
        int n = 0;
        int t0;
        @(posedge clk); #1;
        exp_v.push_back(ref_mem[a]);
        video_req = 1'b1; video_addr = a; t0 = cyc;
        do begin @(negedge clk); n++; end while (!video_ack && n < 100);
        lat = cyc - t0;
        chk(video_ack, "video_ack_timeout", n, 100);
        @(posedge clk); #1;
        video_req = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        int n = 0;
        int t0;
        cexp_t e;
        @(posedge clk); #1;
        e.we = we; e.addr = a; e.data = we ? d : ref_mem[a];
        if (we) ref_mem[a] = d;
        exp_c.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wr_data = d; t0 = cyc;
        do begin @(negedge clk); n++; end while (!cpu_ack && n < 100);
        lat = cyc - t0;
        chk(cpu_ack, "cpu_ack_timeout", n, 100);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    int lat, lat2, n3, t3;
    bit ref_last;
    logic [AW-1:0] a3;

    initial begin
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(13'(i));
        video_req = 0; video_addr = '0; video_urgent = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wr_data = '0;
        v3_req = 0; v3_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({video_ack, cpu_ack, mem_we, busy, grant_cpu} == 5'b0, "reset_ctrl", {video_ack, cpu_ack, mem_we, busy, grant_cpu}, 0);
        chk(mem_addr == '0, "reset_mem_addr", mem_addr, 0);
        chk(video_rd_data == '0 && cpu_rd_data == '0, "reset_rd_data", {video_rd_data, cpu_rd_data}, 0);
        @(posedge clk); #1;
        reset = 0;
        ref_last = 1'b1;

        // Continuous contention, no urgency: grants must alternate starting with the one not granted last.
        grant_order.delete();
        fork
            for (int i = 0; i < 3; i++) video_read(13'(16 + i), lat);
            for (int i = 0; i < 3; i++) cpu_op(1'b0, 13'(13'h150 + i), 8'h00, lat2);
        join
        chk(grant_order.size() == 6, "alt_count", grant_order.size(), 6);
        for (int i = 0; i < 6 && i < grant_order.size(); i++)
            chk(grant_order[i] == (ref_last ^ (i % 2 == 0)), "alt_order", grant_order[i], ref_last ^ (i % 2 == 0));

        video_read(13'h401, lat);
        chk(lat == 3, "video_alone_lat", lat, 3);
        ref_last = 1'b0;

        grant_order.delete();
        fork
            video_read(13'h011, lat);
            cpu_op(1'b0, 13'h151, 8'h00, lat2);
        join
        chk(grant_order.size() == 2 && grant_order[0] == !ref_last, "tie_first", grant_order[0], !ref_last);
        chk(lat2 == 3, "tie_cpu_lat", lat2, 3);
        chk(lat == 7, "tie_video_lat", lat, 7);

        cpu_op(1'b1, 13'h123, 8'h5A, lat);
        chk(lat == 2, "cpu_write_lat", lat, 2);
        cpu_op(1'b0, 13'h123, 8'h00, lat);
        chk(lat == 3, "cpu_read_lat", lat, 3);

        // Urgent video hogging the RAM: the CPU must still be forced through.
        exp_v.delete();
        for (int i = 0; i < 8; i++) exp_v.push_back(ref_mem[13'h0AA]);
        video_addr = 13'h0AA; video_urgent = 1'b1; video_req = 1'b1;
        cpu_op(1'b0, 13'h123, 8'h00, lat);
        chk(lat >= MAXW && lat <= MAXW + 7, "starve_cpu_lat", lat, MAXW + 7);
        video_req = 1'b0; video_urgent = 1'b0;
        @(negedge clk);
        chk(dut1.u_sel.cpu_wait == 0, "starve_wait_clear", int'(dut1.u_sel.cpu_wait), 0);
        repeat (8) @(posedge clk); #1;
        chk(!busy, "starve_idle", busy, 0);
        exp_v.delete();

        // Reset lands while a video read sits in WAIT.
        @(posedge clk); #1; video_addr = 13'h020; video_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; video_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk(busy, "busy_in_wait", busy, 1);
        @(negedge clk);
        chk({video_ack, cpu_ack, mem_we, busy, grant_cpu} == 5'b0, "midreset_ctrl", {video_ack, cpu_ack, mem_we, busy, grant_cpu}, 0);
        chk(mem_addr == '0, "midreset_mem_addr", mem_addr, 0);
        chk(video_rd_data == '0 && cpu_rd_data == '0, "midreset_rd_data", {video_rd_data, cpu_rd_data}, 0);
        @(posedge clk); #1; reset = 1'b0;
        ref_last = 1'b1;
        repeat (4) @(posedge clk);
        grant_order.delete();
        fork
            video_read(13'h020, lat);
            cpu_op(1'b0, 13'h160, 8'h00, lat2);
        join
        chk(grant_order.size() == 2 && grant_order[0] == !ref_last, "postreset_tie_first", grant_order[0], !ref_last);
        chk(lat == 3, "postreset_video_lat", lat, 3);

        // Random mixed traffic: video in 0x000-0x0FF (never written), CPU in 0x100-0x1FF.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    video_urgent = 1'($urandom_range(0, 1));
                    video_read(13'($urandom_range(0, 255)), lat);
                end
                video_urgent = 1'b0;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    cpu_op(1'($urandom_range(0, 1)), 13'(256 + $urandom_range(0, 255)), 8'($urandom), lat2);
                end
            end
        join
        chk(exp_v.size() == 0 && exp_c.size() == 0, "scoreboard_drained", exp_v.size() + exp_c.size(), 0);

        // Three-cycle RAM latency build.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a3 = 13'($urandom_range(0, 8191));
            v3_addr = a3; v3_req = 1'b1; t3 = cyc; n3 = 0;
            do begin @(negedge clk); n3++; end while (!v3_ack && n3 < 50);
            chk(v3_ack && (cyc - t3) == 5, "lat3_ack_time", cyc - t3, 5);
            chk(v3_rd_data == f3(a3), "lat3_rd_data", v3_rd_data, f3(a3));
            @(posedge clk); #1; v3_req = 1'b0;
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
